// File: rtl/bufm_id_alloc.sv
// Buffer-ID allocator: circular free-ID FIFO loaded at init, one-cycle alloc/release.
// Optional BUFM_ID_CHECK_EN adds an in-use bitmap that rejects double/unowned frees.
module bufm_id_alloc #(
    parameter int ID_W   = 5,
    parameter int ID_NUM = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_alloc_req,
    output logic            out_alloc_ack,
    output logic            out_alloc_nack,
    output logic [ID_W-1:0] out_alloc_id,
    input  logic            in_free_wr,
    input  logic [ID_W-1:0] in_free_id,
    output logic            out_init_done,
    output logic [4:0]      bufm_ID_count,
    output logic [7:0]      bufm_ID_cnt,
    output logic            out_free_err,
    output logic [7:0]      out_free_err_cnt
);

    localparam logic [0:0]      ST_INIT  = 1'b0;
    localparam logic [0:0]      ST_RUN   = 1'b1;
    localparam logic [ID_W:0]   FULL_CNT = (ID_W+1)'(ID_NUM);
    localparam logic [ID_W-1:0] LAST_PTR = ID_W'(ID_NUM - 1);
    // Storage sized to the full ID space so any ID_W-bit index is in range; only ID_NUM entries are used.
    localparam int DEPTH = 2 ** ID_W;

    logic [0:0]      state_q, state_d;
    logic [ID_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [ID_W:0]   free_cnt_q, free_cnt_d;
    logic            ack_q, ack_d, nack_q, nack_d, err_q, err_d, done_q, done_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [4:0]      count_q, count_d;
    logic [7:0]      alloc_cnt_q, alloc_cnt_d, err_cnt_q, err_cnt_d;
    logic [ID_W-1:0] fifo_q [DEPTH];
    logic            fifo_we;
    logic [ID_W-1:0] fifo_waddr, fifo_wdata;
    logic            push, pop, free_ok;

`ifdef BUFM_ID_CHECK_EN
    logic [DEPTH-1:0] inuse_q, inuse_d;
    assign free_ok = (free_cnt_q != FULL_CNT) && ({1'b0, in_free_id} < FULL_CNT)
                     && inuse_q[in_free_id];
`else
    assign free_ok = (free_cnt_q != FULL_CNT) && ({1'b0, in_free_id} < FULL_CNT);
`endif

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        free_cnt_d  = free_cnt_q;
        ack_d       = 1'b0;
        nack_d      = 1'b0;
        err_d       = 1'b0;
        done_d      = done_q;
        id_d        = id_q;
        alloc_cnt_d = alloc_cnt_q;
        err_cnt_d   = err_cnt_q;
        fifo_we     = 1'b0;
        fifo_waddr  = wr_ptr_q;
        fifo_wdata  = in_free_id;
        push        = 1'b0;
        pop         = 1'b0;

        if (state_q == ST_INIT) begin
            fifo_we    = 1'b1;
            fifo_wdata = wr_ptr_q;
            nack_d     = in_alloc_req;
            err_d      = in_free_wr;
            if (wr_ptr_q == LAST_PTR) begin
                state_d    = ST_RUN;
                wr_ptr_d   = '0;
                free_cnt_d = FULL_CNT;
                done_d     = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end else begin
            if (in_alloc_req) begin
                if (free_cnt_q != '0) begin
                    pop         = 1'b1;
                    ack_d       = 1'b1;
                    id_d        = fifo_q[rd_ptr_q];
                    rd_ptr_d    = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
                    alloc_cnt_d = alloc_cnt_q + 8'd1;
                end else begin
                    nack_d = 1'b1;
                end
            end
            if (in_free_wr) begin
                if (free_ok) begin
                    push     = 1'b1;
                    fifo_we  = 1'b1;
                    wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            case ({push, pop})
                2'b10:   free_cnt_d = free_cnt_q + 1'b1;
                2'b01:   free_cnt_d = free_cnt_q - 1'b1;
                default: free_cnt_d = free_cnt_q;
            endcase
        end

        if (err_d && (err_cnt_q != 8'hFF))
            err_cnt_d = err_cnt_q + 8'd1;
        count_d = (free_cnt_d > (ID_W+1)'(31)) ? 5'd31 : free_cnt_d[4:0];
    end

`ifdef BUFM_ID_CHECK_EN
    always_comb begin
        inuse_d = inuse_q;
        if (pop)
            inuse_d[fifo_q[rd_ptr_q]] = 1'b1;
        if (push)
            inuse_d[in_free_id] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst_n)
            inuse_q <= '0;
        else
            inuse_q <= inuse_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (fifo_we)
            fifo_q[fifo_waddr] <= fifo_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= ST_INIT;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            free_cnt_q  <= '0;
            ack_q       <= 1'b0;
            nack_q      <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            id_q        <= '0;
            count_q     <= '0;
            alloc_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            free_cnt_q  <= free_cnt_d;
            ack_q       <= ack_d;
            nack_q      <= nack_d;
            err_q       <= err_d;
            done_q      <= done_d;
            id_q        <= id_d;
            count_q     <= count_d;
            alloc_cnt_q <= alloc_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_alloc_ack    = ack_q;
    assign out_alloc_nack   = nack_q;
    assign out_alloc_id     = id_q;
    assign out_init_done    = done_q;
    assign bufm_ID_count    = count_q;
    assign bufm_ID_cnt      = alloc_cnt_q;
    assign out_free_err     = err_q;
    assign out_free_err_cnt = err_cnt_q;

endmodule
